l2_arbiter: RTL and testbench

Two-port arbiter that shares the single L2 cache line interface between the L1 instruction cache (read-only) and the L1 data cache (read/write). It accepts full 256-bit line requests from both L1s and grants one at a time using round-robin priority. It forwards the granted request to the L2 cache and routes the L2 response back to the winner. It sits between the L1 caches and the L2 cache, with only one L2 transaction outstanding at a time.

---
 rtl/l2_arbiter.sv | 119 +++++++++++
 tb/tb_l2_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the L1 I-cache and D-cache.
// One L2 transaction is in flight at a time; a one-cycle RELEASE gap follows each completion.
module l2_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [s_addr-1:0] icache_address,
  output logic [s_line-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [s_addr-1:0] dcache_address,
  input  logic [s_line-1:0] dcache_wdata,
  output logic [s_line-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t state_r;
  logic   last_grant_r;
  logic   i_req_s;
  logic   d_req_s;

  assign i_req_s = icache_read;
  assign d_req_s = dcache_read | dcache_write;

  // Arbitration state and round-robin history; a tie goes to whoever was not served last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_I;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_s && d_req_s) begin
            state_r <= (last_grant_r == LAST_I) ? GRANT_D : GRANT_I;
          end else if (i_req_s) begin
            state_r <= GRANT_I;
          end else if (d_req_s) begin
            state_r <= GRANT_D;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT_I: begin
          if (l2_resp) begin
            state_r      <= RELEASE;
            last_grant_r <= LAST_I;
          end else begin
            state_r <= GRANT_I;
          end
        end
        GRANT_D: begin
          if (l2_resp) begin
            state_r      <= RELEASE;
            last_grant_r <= LAST_D;
          end else begin
            state_r <= GRANT_D;
          end
        end
        RELEASE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // L2 request and L1 response steering for the current owner
  always_comb begin
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_address  = {s_addr{1'b0}};
    l2_wdata    = {s_line{1'b0}};
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    case (state_r)
      GRANT_I: begin
        l2_read     = 1'b1;
        l2_address  = icache_address;
        icache_resp = l2_resp;
      end
      GRANT_D: begin
        l2_read     = dcache_read;
        l2_write    = dcache_write;
        l2_address  = dcache_address;
        l2_wdata    = dcache_wdata;
        dcache_resp = l2_resp;
      end
      default: begin
        l2_read = 1'b0;
      end
    endcase
  end

  assign busy = (state_r != IDLE);

  // Read data is forced low under reset so every output is quiet while rst is held
  assign icache_rdata = rst ? l2_rdata : {s_line{1'b0}};
  assign dcache_rdata = rst ? l2_rdata : {s_line{1'b0}};

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_l2_arbiter;

  logic         clk;
  logic         rst;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read;
  logic         dcache_write;
  logic [31:0]  dcache_address;
  logic [255:0] dcache_wdata;
  logic [255:0] dcache_rdata;
  logic         dcache_resp;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;
  logic         busy;

  int checks;
  int errors;

  l2_arbiter #(.s_line(256), .s_addr(32)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L1 protocol rules the bench itself must respect
  a_no_rw: assert property (@(posedge clk) disable iff (!rst) !(dcache_read && dcache_write))
    else $error("protocol: dcache_read and dcache_write together");
  a_i_hold: assert property (@(posedge clk) disable iff (!rst) (icache_read && !icache_resp) |=> icache_read)
    else $error("protocol: icache request dropped before resp");
  a_d_hold: assert property (@(posedge clk) disable iff (!rst)
      ((dcache_read || dcache_write) && !dcache_resp) |=> (dcache_read || dcache_write))
    else $error("protocol: dcache request dropped before resp");

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    icache_read    = 1'b0;
    icache_address = 32'h0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = 32'h0;
    dcache_wdata   = 256'h0;
    l2_rdata       = 256'h0;
    l2_resp        = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    l2_resp      = 1'b1;
    l2_rdata     = {32{8'h5A}};
    dcache_write = 1'b1;
    repeat (2) @(posedge clk);
    sample_point();
    checks++;
    if ({busy, l2_read, l2_write, icache_resp, dcache_resp} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/rd/wr/iresp/dresp=%b required 00000",
               {busy, l2_read, l2_write, icache_resp, dcache_resp});
    end
    checks++;
    if ((|{l2_address, l2_wdata, icache_rdata, dcache_rdata}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: addr=%h rdata_i=%h required all zero", l2_address, icache_rdata);
    end
    drive_point();
    rst            = 1'b1;
    l2_resp        = 1'b0;
    dcache_address = 32'h0000_2020;
    dcache_wdata   = {8{32'h1234_5678}};
    sample_point();
    drive_point();
    sample_point();
    checks++;
    if (l2_write !== 1'b1 || busy !== 1'b1 || l2_address !== 32'h0000_2020) begin
      errors++;
      $display("FAIL reset_pre_grant: wr=%b busy=%b addr=%h required 1 1 00002020", l2_write, busy, l2_address);
    end
    l2_resp = 1'b1;
    #1;
    checks++;
    if (dcache_resp !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_resp: dcache_resp=%b required 1", dcache_resp);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({l2_write, dcache_resp, busy, l2_read} !== 4'b0 || l2_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: wr/dresp/busy/rd=%b addr=%h required 0000 0",
               {l2_write, dcache_resp, busy, l2_read}, l2_address);
    end
    l2_resp        = 1'b0;
    icache_read    = 1'b1;
    icache_address = 32'h0000_1000;
    @(posedge clk);
    #1 rst = 1'b1;
    sample_point();
    drive_point();
    sample_point();
    checks++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 32'h0000_2020) begin
      errors++;
      $display("FAIL reset_first_tie: wr=%b rd=%b addr=%h required D grant 1 0 00002020",
               l2_write, l2_read, l2_address);
    end
  endtask

  task automatic test_single_read();
    logic [255:0] pat;
    pat = {32{8'hA5}};
    apply_reset();
    icache_read    = 1'b1;
    icache_address = 32'h0000_1000;
    sample_point();
    checks++;
    if (l2_read !== 1'b0) begin
      errors++;
      $display("FAIL iread_latency: l2_read=%b required 0 in request cycle", l2_read);
    end
    for (int c = 1; c <= 5; c++) begin
      drive_point();
      if (c == 5) begin
        l2_resp  = 1'b1;
        l2_rdata = pat;
      end
      sample_point();
      checks++;
      if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 32'h0000_1000 || l2_wdata !== 256'h0) begin
        errors++;
        $display("FAIL iread_req c%0d: rd=%b wr=%b addr=%h required 1 0 00001000", c, l2_read, l2_write, l2_address);
      end
      checks++;
      if (icache_resp !== 1'(c == 5) || dcache_resp !== 1'b0) begin
        errors++;
        $display("FAIL iread_resp c%0d: iresp=%b dresp=%b required %b 0", c, icache_resp, dcache_resp, 1'(c == 5));
      end
    end
    checks++;
    if (icache_rdata !== pat) begin
      errors++;
      $display("FAIL iread_data: icache_rdata=%h required %h", icache_rdata, pat);
    end
    drive_point();
    l2_resp     = 1'b0;
    icache_read = 1'b0;
    sample_point();
    checks++;
    if (l2_read !== 1'b0 || icache_resp !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL iread_release: rd=%b iresp=%b busy=%b required 0 0 1", l2_read, icache_resp, busy);
    end
    drive_point();
    sample_point();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL iread_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_dcache_write();
    int d_pulses;
    int i_pulses;
    apply_reset();
    d_pulses = 0;
    i_pulses = 0;
    dcache_write   = 1'b1;
    dcache_address = 32'h0000_2020;
    dcache_wdata   = {8{32'h1234_5678}};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) drive_point();
      l2_resp = 1'(c == 4);
      if (c == 5) dcache_write = 1'b0;
      sample_point();
      if (dcache_resp === 1'b1) d_pulses++;
      if (icache_resp === 1'b1) i_pulses++;
      if (c >= 1 && c <= 4) begin
        checks++;
        if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 32'h0000_2020 ||
            l2_wdata !== {8{32'h1234_5678}}) begin
          errors++;
          $display("FAIL dwrite_req c%0d: wr=%b rd=%b addr=%h required 1 0 00002020", c, l2_write, l2_read, l2_address);
        end
      end else begin
        checks++;
        if (l2_write !== 1'b0 || l2_read !== 1'b0) begin
          errors++;
          $display("FAIL dwrite_noreq c%0d: wr=%b rd=%b required 0 0", c, l2_write, l2_read);
        end
      end
      if (c == 4) begin
        checks++;
        if (dcache_resp !== 1'b1) begin
          errors++;
          $display("FAIL dwrite_resp: dcache_resp=%b required 1 at cycle 4", dcache_resp);
        end
      end
    end
    checks++;
    if (d_pulses != 1 || i_pulses != 0) begin
      errors++;
      $display("FAIL dwrite_pulses: dresp=%0d iresp=%0d required 1 0", d_pulses, i_pulses);
    end
  endtask

  task automatic test_tie();
    int d_resp_cyc;
    int i_start;
    apply_reset();
    d_resp_cyc     = -1;
    i_start        = -1;
    icache_read    = 1'b1;
    icache_address = 32'h0000_1100;
    dcache_read    = 1'b1;
    dcache_address = 32'h0000_2200;
    sample_point();
    for (int c = 1; c < 16 && i_start < 0; c++) begin
      drive_point();
      l2_resp = 1'(c == 3);
      if (d_resp_cyc >= 0 && c == d_resp_cyc + 1) dcache_read = 1'b0;
      sample_point();
      if (c == 1) begin
        checks++;
        if (l2_read !== 1'b1 || l2_address !== 32'h0000_2200) begin
          errors++;
          $display("FAIL tie_d_first: rd=%b addr=%h required 1 00002200", l2_read, l2_address);
        end
      end
      if (dcache_resp === 1'b1) d_resp_cyc = c;
      checks++;
      if (icache_resp !== 1'b0) begin
        errors++;
        $display("FAIL tie_no_iresp c%0d: icache_resp=%b required 0", c, icache_resp);
      end
      if (l2_read === 1'b1 && l2_address === 32'h0000_1100) i_start = c;
    end
    checks++;
    if (d_resp_cyc != 3 || i_start != 6) begin
      errors++;
      $display("FAIL tie_i_after: dresp cycle=%0d I start=%0d required 3 6", d_resp_cyc, i_start);
    end
  endtask

  task automatic test_contention();
    int   n_grants;
    int   i_gap;
    int   d_gap;
    int   owner;
    logic prev_req;
    logic prev_resp;
    logic req;
    logic d_wr;
    apply_reset();
    n_grants  = 0;
    i_gap     = 0;
    d_gap     = 0;
    prev_req  = 1'b0;
    prev_resp = 1'b0;
    d_wr      = 1'b1;
    icache_read    = 1'b1;
    icache_address = 32'h0000_1000;
    dcache_write   = 1'b1;
    dcache_address = 32'h0000_2000;
    dcache_wdata   = {8{32'hCAFE_F00D}};
    for (int c = 0; c < 300 && n_grants < 6; c++) begin
      if (c > 0) begin
        drive_point();
        if (i_gap == 2) begin
          icache_read = 1'b0;
          i_gap = 1;
        end else if (i_gap == 1) begin
          icache_read = 1'b1;
          i_gap = 0;
        end
        if (d_gap == 2) begin
          dcache_read  = 1'b0;
          dcache_write = 1'b0;
          d_gap = 1;
        end else if (d_gap == 1) begin
          d_wr         = ~d_wr;
          dcache_write = d_wr;
          dcache_read  = ~d_wr;
          d_gap = 0;
        end
        l2_resp = prev_req && !prev_resp && ($urandom_range(0, 2) == 0);
        for (int k = 0; k < 8; k++) l2_rdata[k*32 +: 32] = $urandom();
      end
      sample_point();
      req = l2_read | l2_write;
      if (req && !prev_req) begin
        owner = (l2_address === 32'h0000_1000) ? 1 : 2;
        checks++;
        if (owner != ((n_grants % 2 == 0) ? 2 : 1)) begin
          errors++;
          $display("FAIL contention_order grant%0d: owner=%0d required %0d (1=I 2=D)",
                   n_grants, owner, (n_grants % 2 == 0) ? 2 : 1);
        end
        n_grants++;
      end
      checks++;
      if (icache_resp === 1'b1 && dcache_resp === 1'b1) begin
        errors++;
        $display("FAIL contention_dual_resp c%0d: both resp high, required at most one", c);
      end
      if (prev_resp) begin
        checks++;
        if (req !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
          errors++;
          $display("FAIL contention_release c%0d: req=%b iresp=%b dresp=%b required 0 0 0",
                   c, req, icache_resp, dcache_resp);
        end
      end
      if (icache_resp === 1'b1) i_gap = 2;
      if (dcache_resp === 1'b1) d_gap = 2;
      prev_resp = l2_resp && req;
      prev_req  = req;
    end
    checks++;
    if (n_grants != 6) begin
      errors++;
      $display("FAIL contention_count: grants=%0d required 6 within budget", n_grants);
    end
  endtask

  task automatic test_stray_resp();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) drive_point();
      l2_resp  = 1'b1;
      l2_rdata = {8{32'hDEAD_BEEF}} ^ 256'(c);
      sample_point();
      checks++;
      if ({icache_resp, dcache_resp, busy, l2_read, l2_write} !== 5'b0) begin
        errors++;
        $display("FAIL stray_idle c%0d: iresp/dresp/busy/rd/wr=%b required 00000",
                 c, {icache_resp, dcache_resp, busy, l2_read, l2_write});
      end
      checks++;
      if (icache_rdata !== l2_rdata || dcache_rdata !== l2_rdata) begin
        errors++;
        $display("FAIL stray_rdata c%0d: rdata=%h required %h", c, icache_rdata, l2_rdata);
      end
    end
    drive_point();
    l2_resp        = 1'b0;
    icache_read    = 1'b1;
    icache_address = 32'h0000_3000;
    sample_point();
    drive_point();
    sample_point();
    checks++;
    if (l2_read !== 1'b1 || l2_address !== 32'h0000_3000) begin
      errors++;
      $display("FAIL stray_then_grant: rd=%b addr=%h required 1 00003000", l2_read, l2_address);
    end
  endtask

  task automatic test_random();
    int           owner;
    int           last;
    int           free_at;
    int           rel_cyc;
    logic         i_done;
    logic         d_done;
    logic         ireq;
    logic         dreq;
    logic [4:0]   exp_ctl;
    logic [31:0]  exp_addr;
    logic [255:0] exp_wd;
    apply_reset();
    owner   = 0;
    last    = 1;
    free_at = 1;
    rel_cyc = -1;
    i_done  = 1'b0;
    d_done  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) drive_point();
      if (i_done) begin
        icache_read = 1'b0;
        i_done = 1'b0;
      end else if (!icache_read && $urandom_range(0, 2) == 0) begin
        icache_read    = 1'b1;
        icache_address = 32'h0001_0000 | ($urandom() & 32'h0000_FFE0);
      end
      if (d_done) begin
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        d_done = 1'b0;
      end else if (!(dcache_read || dcache_write) && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) dcache_write = 1'b1;
        else dcache_read = 1'b1;
        dcache_address = 32'h0002_0000 | ($urandom() & 32'h0000_FFE0);
        for (int k = 0; k < 8; k++) dcache_wdata[k*32 +: 32] = $urandom();
      end
      l2_resp = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 8; k++) l2_rdata[k*32 +: 32] = $urandom();
      sample_point();
      // expected outputs follow from who owns the L2 port this cycle
      exp_ctl[4] = (owner != 0) || (c == rel_cyc);
      exp_ctl[3] = (owner == 1) ? 1'b1 : (owner == 2) ? dcache_read : 1'b0;
      exp_ctl[2] = (owner == 2) ? dcache_write : 1'b0;
      exp_ctl[1] = (owner == 1) && l2_resp;
      exp_ctl[0] = (owner == 2) && l2_resp;
      exp_addr   = (owner == 1) ? icache_address : (owner == 2) ? dcache_address : 32'h0;
      exp_wd     = (owner == 2) ? dcache_wdata : 256'h0;
      checks++;
      if ({busy, l2_read, l2_write, icache_resp, dcache_resp} !== exp_ctl) begin
        errors++;
        $display("FAIL rand_ctl c%0d: busy/rd/wr/iresp/dresp=%b required %b",
                 c, {busy, l2_read, l2_write, icache_resp, dcache_resp}, exp_ctl);
      end
      checks++;
      if (l2_address !== exp_addr) begin
        errors++;
        $display("FAIL rand_addr c%0d: l2_address=%h required %h", c, l2_address, exp_addr);
      end
      checks++;
      if (l2_wdata !== exp_wd) begin
        errors++;
        $display("FAIL rand_wdata c%0d: l2_wdata=%h required %h", c, l2_wdata, exp_wd);
      end
      checks++;
      if (icache_rdata !== l2_rdata || dcache_rdata !== l2_rdata) begin
        errors++;
        $display("FAIL rand_rdata c%0d: i=%h d=%h required %h", c, icache_rdata, dcache_rdata, l2_rdata);
      end
      i_done = exp_ctl[1];
      d_done = exp_ctl[0];
      ireq = icache_read;
      dreq = dcache_read || dcache_write;
      if (owner != 0 && l2_resp) begin
        last    = owner;
        owner   = 0;
        rel_cyc = c + 1;
        free_at = c + 3;
      end else if (owner == 0 && c + 1 >= free_at && (ireq || dreq)) begin
        owner = (ireq && dreq) ? ((last == 1) ? 2 : 1) : (ireq ? 1 : 2);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_dcache_write();
    test_tie();
    test_contention();
    test_stray_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
